// File: rtl/exec_control.sv
// Execute-stage control unit sitting directly behind cpu_core.
//
// Decodes the fetched instruction word against the one-hot micro-step vector. It holds a
// 4 x 8-bit register file, the Z/C flags and a 9-bit ALU result latch (tmp). It also drives
// instruction-completion, branch and halt signalling back to the core.
//
// Ports:
//   clk            - system clock, rising edge
//   reset          - synchronous, active-low; clears register file, flags, tmp, illegal
//   ir             - instruction: [31:24] opcode, [23:16] op1, [15:8] op2, [7:0] op3
//   clks           - one-hot micro-step (bit n = Tn)
//   state          - core state; writes only happen when state == STATE_EXEC
//   end_inst       - instruction completes at the current step
//   jmp_inst       - current instruction is a branch
//   hlt_inst       - halt request
//   jmp_address    - branch target, always op1
//   inst_condition - branch/step condition true
//   regs           - {R3,R2,R1,R0} for observation
//   flags          - {C,Z}
//   illegal        - sticky, set when an undefined opcode executes

module exec_control #(
    parameter logic [1:0]  STATE_EXEC = 2'd2,
    parameter int unsigned STEP_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ir,
    input  logic [STEP_W-1:0] clks,
    input  logic [1:0]        state,
    output logic              end_inst,
    output logic              jmp_inst,
    output logic              hlt_inst,
    output logic [7:0]        jmp_address,
    output logic              inst_condition,
    output logic [31:0]       regs,
    output logic [1:0]        flags,
    output logic              illegal
);

    localparam logic [7:0] OpNop = 8'h00;
    localparam logic [7:0] OpLdi = 8'h01;
    localparam logic [7:0] OpMov = 8'h02;
    localparam logic [7:0] OpAdd = 8'h03;
    localparam logic [7:0] OpSub = 8'h04;
    localparam logic [7:0] OpAnd = 8'h05;
    localparam logic [7:0] OpOr  = 8'h06;
    localparam logic [7:0] OpCmp = 8'h07;
    localparam logic [7:0] OpJmp = 8'h08;
    localparam logic [7:0] OpJz  = 8'h09;
    localparam logic [7:0] OpJc  = 8'h0A;
    localparam logic [7:0] OpJnz = 8'h0B;
    localparam logic [7:0] OpHlt = 8'hFF;

    logic [7:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
    logic [1:0] op1_idx;
    logic [1:0] op2_idx;
    logic [1:0] op3_idx;

    assign opcode  = ir[31:24];
    assign op1     = ir[23:16];
    assign op2     = ir[15:8];
    assign op1_idx = ir[17:16];
    assign op2_idx = ir[9:8];
    assign op3_idx = ir[1:0];

    // Only the low two bits of op2/op3 select registers.
    logic unused_ir;
    assign unused_ir = ^{ir[15:10], ir[7:2]};

    logic [7:0] rf_q [4];
    logic [8:0] tmp_q;
    logic       z_q;
    logic       c_q;
    logic       illegal_q;

    logic exec;
    logic t0;
    logic t1;

    assign exec = (state == STATE_EXEC);
    // Exact compares reject zero and multi-hot step vectors.
    assign t0   = exec && (clks == STEP_W'(1));
    assign t1   = exec && (clks == STEP_W'(2));

    logic is_alu;
    logic is_logic_op;
    logic is_known;

    assign is_alu      = (opcode >= OpAdd) && (opcode <= OpCmp);
    assign is_logic_op = (opcode == OpAnd) || (opcode == OpOr);
    assign is_known    = (opcode <= OpJnz) || (opcode == OpHlt);

    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [8:0] alu_res;

    assign alu_a = rf_q[op2_idx];
    assign alu_b = rf_q[op3_idx];

    always_comb begin
        alu_res = 9'd0;
        case (opcode)
            OpAdd:        alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            OpSub, OpCmp: alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            OpAnd:        alu_res = {1'b0, alu_a & alu_b};
            OpOr:         alu_res = {1'b0, alu_a | alu_b};
            default:      alu_res = 9'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                rf_q[i] <= 8'd0;
            end
            tmp_q     <= 9'd0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (t0) begin
                case (opcode)
                    OpLdi: rf_q[op1_idx] <= op2;
                    OpMov: rf_q[op1_idx] <= rf_q[op2_idx];
                    OpAdd, OpSub, OpAnd, OpOr, OpCmp: tmp_q <= alu_res;
                    default: begin
                        if (!is_known) begin
                            illegal_q <= 1'b1;
                        end
                    end
                endcase
            end
            // Commit the result latched at T0; CMP only touches the flags.
            if (t1 && is_alu) begin
                if (opcode != OpCmp) begin
                    rf_q[op1_idx] <= tmp_q[7:0];
                end
                z_q <= (tmp_q[7:0] == 8'd0);
                c_q <= is_logic_op ? 1'b0 : tmp_q[8];
            end
        end
    end

    always_comb begin
        end_inst       = 1'b0;
        jmp_inst       = 1'b0;
        hlt_inst       = 1'b0;
        inst_condition = 1'b0;
        if (exec) begin
            inst_condition = 1'b1;
            case (opcode)
                OpJmp: begin
                    jmp_inst = 1'b1;
                    end_inst = t0;
                end
                OpJz: begin
                    jmp_inst       = 1'b1;
                    end_inst       = t0;
                    inst_condition = z_q;
                end
                OpJc: begin
                    jmp_inst       = 1'b1;
                    end_inst       = t0;
                    inst_condition = c_q;
                end
                OpJnz: begin
                    jmp_inst       = 1'b1;
                    end_inst       = t0;
                    inst_condition = ~z_q;
                end
                OpHlt: hlt_inst = 1'b1;
                OpAdd, OpSub, OpAnd, OpOr, OpCmp: end_inst = t1;
                // NOP, LDI, MOV and undefined opcodes all finish at T0.
                default: end_inst = t0;
            endcase
        end
    end

    assign jmp_address = op1;
    assign regs        = {rf_q[3], rf_q[2], rf_q[1], rf_q[0]};
    assign flags       = {c_q, z_q};
    assign illegal     = illegal_q;

    logic unused_nop;
    assign unused_nop = ^{OpNop};

endmodule
